// File: rtl/instr_cache.sv
// Direct-mapped instruction cache sitting between the fetch stage and backing memory.
// Hits respond one cycle after accept; misses refill the whole line one beat at a time.
module instr_cache #(
  parameter int ADDR_WIDTH     = 32,
  parameter int INSTR_WIDTH    = 32,
  parameter int NUM_LINES      = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_req_valid,
  input  logic [ADDR_WIDTH-1:0]  i_req_addr,
  output logic                   o_req_ready,
  input  logic                   i_kill,
  input  logic                   i_flush,
  output logic                   o_rsp_valid,
  output logic [INSTR_WIDTH-1:0] o_rsp_instr,
  output logic [ADDR_WIDTH-1:0]  o_rsp_addr,
  output logic                   o_mem_req_valid,
  output logic [ADDR_WIDTH-1:0]  o_mem_addr,
  input  logic                   i_mem_req_ready,
  input  logic                   i_mem_rsp_valid,
  input  logic [INSTR_WIDTH-1:0] i_mem_rsp_data
);

  localparam int WORD_BITS = $clog2(WORDS_PER_LINE);
  localparam int OFF_BITS  = WORD_BITS + 2;
  localparam int IDX_BITS  = $clog2(NUM_LINES);
  localparam int TAG_BITS  = ADDR_WIDTH - OFF_BITS - IDX_BITS;
  localparam int NUM_WORDS = NUM_LINES * WORDS_PER_LINE;

  typedef enum logic [1:0] {
    IDLE,
    MISS_REQ,
    REFILL,
    RESPOND
  } state_e;

  state_e                  state_q;
  logic [NUM_LINES-1:0]    valid_q;
  logic [TAG_BITS-1:0]     tag_q  [NUM_LINES];
  logic [INSTR_WIDTH-1:0]  data_q [NUM_WORDS];
  logic [WORD_BITS-1:0]    beat_q;
  logic [WORD_BITS-1:0]    beat_d;
  logic [ADDR_WIDTH-1:0]   req_addr_q;
  logic                    rsp_valid_q;
  logic [INSTR_WIDTH-1:0]  rsp_instr_q;
  logic [ADDR_WIDTH-1:0]   rsp_addr_q;
  logic                    mem_req_valid_q;
  logic                    kill_pending_q;
  logic                    flush_pending_q;

  logic [IDX_BITS-1:0]     req_idx;
  logic [WORD_BITS-1:0]    req_word;
  logic [TAG_BITS-1:0]     req_tag;
  logic [IDX_BITS-1:0]     miss_idx;
  logic [WORD_BITS-1:0]    miss_word;
  logic [TAG_BITS-1:0]     miss_tag;
  logic                    lookup_hit;
  logic                    accept;
  logic                    beat_fire;
  logic                    last_beat;

  assign req_idx   = i_req_addr[OFF_BITS +: IDX_BITS];
  assign req_word  = i_req_addr[2 +: WORD_BITS];
  assign req_tag   = i_req_addr[ADDR_WIDTH-1 -: TAG_BITS];
  assign miss_idx  = req_addr_q[OFF_BITS +: IDX_BITS];
  assign miss_word = req_addr_q[2 +: WORD_BITS];
  assign miss_tag  = req_addr_q[ADDR_WIDTH-1 -: TAG_BITS];

  assign lookup_hit  = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign o_req_ready = (state_q == IDLE) && !i_flush && !flush_pending_q && !i_reset;
  assign accept      = i_req_valid && o_req_ready;
  assign beat_fire   = (state_q == REFILL) && i_mem_rsp_valid;
  assign last_beat   = beat_fire && (&beat_q);
  assign beat_d      = last_beat ? '0 : beat_q + {{(WORD_BITS-1){1'b0}}, 1'b1};

  // A kill arriving in the response cycle itself must still squash the pulse.
  assign o_rsp_valid     = rsp_valid_q && !i_kill;
  assign o_rsp_instr     = rsp_instr_q;
  assign o_rsp_addr      = rsp_addr_q;
  assign o_mem_req_valid = mem_req_valid_q;
  assign o_mem_addr      = {req_addr_q[ADDR_WIDTH-1:OFF_BITS], {OFF_BITS{1'b0}}};

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q         <= IDLE;
      valid_q         <= '0;
      beat_q          <= '0;
      req_addr_q      <= '0;
      rsp_valid_q     <= 1'b0;
      rsp_instr_q     <= '0;
      rsp_addr_q      <= '0;
      mem_req_valid_q <= 1'b0;
      kill_pending_q  <= 1'b0;
      flush_pending_q <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      if (state_q != IDLE) begin
        if (i_kill)  kill_pending_q  <= 1'b1;
        if (i_flush) flush_pending_q <= 1'b1;
      end
      case (state_q)
        IDLE: begin
          kill_pending_q <= 1'b0;
          if (i_flush || flush_pending_q) begin
            valid_q         <= '0;
            flush_pending_q <= 1'b0;
          end else if (accept) begin
            if (lookup_hit) begin
              rsp_valid_q <= 1'b1;
              rsp_instr_q <= data_q[{req_idx, req_word}];
              rsp_addr_q  <= i_req_addr;
            end else begin
              req_addr_q      <= i_req_addr;
              mem_req_valid_q <= 1'b1;
              state_q         <= MISS_REQ;
            end
          end
        end
        MISS_REQ: begin
          if (i_mem_req_ready) begin
            mem_req_valid_q <= 1'b0;
            beat_q          <= '0;
            state_q         <= REFILL;
          end
        end
        REFILL: begin
          if (beat_fire) begin
            beat_q <= beat_d;
            if (beat_q == miss_word) rsp_instr_q <= i_mem_rsp_data;
            if (last_beat) begin
              valid_q[miss_idx] <= 1'b1;
              rsp_valid_q       <= !(kill_pending_q || i_kill);
              rsp_addr_q        <= req_addr_q;
              state_q           <= RESPOND;
            end
          end
        end
        RESPOND: begin
          kill_pending_q <= 1'b0;
          state_q        <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Data and tag storage need no reset; the valid bits alone qualify them.
  always_ff @(posedge i_clk) begin
    if (beat_fire) begin
      data_q[{miss_idx, beat_q}] <= i_mem_rsp_data;
      if (&beat_q) tag_q[miss_idx] <= miss_tag;
    end
  end

endmodule

// File: tb/tb_instr_cache.sv
// Self-checking bench for instr_cache: directed scenarios plus randomized traffic,
// with a transaction-level cache model checked against the DUT every cycle.
module tb_instr_cache;

  logic        clk;
  logic        i_reset;
  logic        i_req_valid;
  logic [31:0] i_req_addr;
  logic        o_req_ready;
  logic        i_kill;
  logic        i_flush;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_instr;
  logic [31:0] o_rsp_addr;
  logic        o_mem_req_valid;
  logic [31:0] o_mem_addr;
  logic        i_mem_req_ready;
  logic        i_mem_rsp_valid;
  logic [31:0] i_mem_rsp_data;

  instr_cache dut (
    .i_clk           (clk),
    .i_reset         (i_reset),
    .i_req_valid     (i_req_valid),
    .i_req_addr      (i_req_addr),
    .o_req_ready     (o_req_ready),
    .i_kill          (i_kill),
    .i_flush         (i_flush),
    .o_rsp_valid     (o_rsp_valid),
    .o_rsp_instr     (o_rsp_instr),
    .o_rsp_addr      (o_rsp_addr),
    .o_mem_req_valid (o_mem_req_valid),
    .o_mem_addr      (o_mem_addr),
    .i_mem_req_ready (i_mem_req_ready),
    .i_mem_rsp_valid (i_mem_rsp_valid),
    .i_mem_rsp_data  (i_mem_rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Backing memory contents: unique per word, 0xA0..0xA3 for the line at 0x10.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    logic [31:0] lineNum;
    logic [31:0] hi;
    lineNum = {4'b0, a[31:4]};
    hi      = (lineNum - 32'd1) << 8;
    return hi | (32'hA0 + {30'b0, a[3:2]});
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] a, input logic k, input logic f);
    @(negedge clk);
    i_req_valid = v;
    i_req_addr  = a;
    i_kill      = k;
    i_flush     = f;
  endtask

  task automatic idleCycle();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    #4;
  endtask

  // Backing memory responder: random grant delay, random beat gaps, stray beats while idle.
  int          mState;
  int          beatsSent;
  int          beatLimit;
  logic [31:0] memBase;

  initial begin
    i_mem_req_ready = 1'b0;
    i_mem_rsp_valid = 1'b0;
    i_mem_rsp_data  = '0;
    mState    = 0;
    beatsSent = 0;
    beatLimit = 4;
    memBase   = '0;
    forever begin
      @(negedge clk);
      if (i_reset) begin
        mState          = 0;
        beatsSent       = 0;
        i_mem_req_ready = 1'b0;
        i_mem_rsp_valid = 1'b0;
        i_mem_rsp_data  = '0;
      end else begin
        if (mState == 1 && i_mem_req_ready) begin
          mState    = 2;
          beatsSent = 0;
        end else if (mState == 2 && i_mem_rsp_valid) begin
          beatsSent++;
          if (beatsSent == 4) mState = 0;
        end
        if (mState == 0 && o_mem_req_valid) begin
          mState  = 1;
          memBase = o_mem_addr;
        end
        i_mem_req_ready = 1'b0;
        i_mem_rsp_valid = 1'b0;
        i_mem_rsp_data  = '0;
        if (mState == 1) begin
          i_mem_req_ready = ($urandom_range(0, 2) != 0);
        end else if (mState == 2) begin
          if (beatsSent < beatLimit && $urandom_range(0, 3) != 0) begin
            i_mem_rsp_valid = 1'b1;
            i_mem_rsp_data  = memWord(memBase + 32'(4 * beatsSent));
          end
        end else if ($urandom_range(0, 9) == 0) begin
          i_mem_rsp_valid = 1'b1;
          i_mem_rsp_data  = $urandom;
        end
      end
    end
  end

  // Reference model: cache contents plus the single in-flight miss transaction.
  bit          mValid [16];
  logic [23:0] mTag   [16];
  bit          inMiss;
  bit          reqAccepted;
  int          beats;
  logic [31:0] missAddr;
  bit          killSeen;
  bit          flushPend;
  bit          rspDue;
  logic [31:0] rspAddr;
  bit          nextRsp;
  bit          expRsp;

  task automatic modelReset();
    for (int i = 0; i < 16; i++) mValid[i] = 1'b0;
    inMiss = 0; reqAccepted = 0; beats = 0; missAddr = '0;
    killSeen = 0; flushPend = 0; rspDue = 0; rspAddr = '0;
  endtask

  initial begin
    modelReset();
    forever begin
      @(negedge clk);
      #4;
      if (i_reset) begin
        checkOutput("rst_ready", {31'b0, o_req_ready}, 32'h0);
        checkOutput("rst_rsp_valid", {31'b0, o_rsp_valid}, 32'h0);
        checkOutput("rst_mem_valid", {31'b0, o_mem_req_valid}, 32'h0);
        checkOutput("rst_rsp_instr", o_rsp_instr, 32'h0);
        checkOutput("rst_rsp_addr", o_rsp_addr, 32'h0);
        checkOutput("rst_mem_addr", o_mem_addr, 32'h0);
        modelReset();
      end else begin
        checkOutput("ready", {31'b0, o_req_ready}, {31'b0, !inMiss && !i_flush && !flushPend});
        checkOutput("mem_valid", {31'b0, o_mem_req_valid}, {31'b0, inMiss && !reqAccepted});
        if (inMiss && !reqAccepted)
          checkOutput("mem_addr", o_mem_addr, {missAddr[31:4], 4'b0});
        expRsp = rspDue && !i_kill;
        checkOutput("rsp_valid", {31'b0, o_rsp_valid}, {31'b0, expRsp});
        if (expRsp) begin
          checkOutput("rsp_instr", o_rsp_instr, memWord(rspAddr));
          checkOutput("rsp_addr", o_rsp_addr, rspAddr);
        end
        nextRsp = 0;
        if (inMiss) begin
          if (i_kill)  killSeen  = 1;
          if (i_flush) flushPend = 1;
          if (!reqAccepted) begin
            if (i_mem_req_ready) reqAccepted = 1;
          end else if (beats < 4) begin
            if (i_mem_rsp_valid) begin
              beats++;
              if (beats == 4) begin
                mValid[missAddr[7:4]] = 1'b1;
                mTag[missAddr[7:4]]   = missAddr[31:8];
                nextRsp = !killSeen;
                rspAddr = missAddr;
              end
            end
          end else begin
            inMiss   = 0;
            killSeen = 0;
          end
        end else if (i_flush || flushPend) begin
          for (int i = 0; i < 16; i++) mValid[i] = 1'b0;
          flushPend = 0;
        end else if (i_req_valid) begin
          if (mValid[i_req_addr[7:4]] && mTag[i_req_addr[7:4]] == i_req_addr[31:8]) begin
            nextRsp = 1;
            rspAddr = i_req_addr;
          end else begin
            inMiss      = 1;
            reqAccepted = 0;
            beats       = 0;
            missAddr    = i_req_addr;
          end
        end
        rspDue = nextRsp;
      end
    end
  end

  task automatic waitMemReq(input string name, input logic [31:0] expAddr);
    bit seen;
    seen = 0;
    for (int n = 0; n < 40 && !seen; n++) begin
      idleCycle();
      if (o_mem_req_valid) seen = 1;
    end
    checkOutput({name, "_memreq"}, {31'b0, seen}, 32'h1);
    if (seen) checkOutput({name, "_memaddr"}, o_mem_addr, expAddr);
  endtask

  task automatic waitRsp(input string name, input logic [31:0] expInstr, input logic [31:0] expAddr);
    bit seen;
    seen = 0;
    for (int n = 0; n < 80 && !seen; n++) begin
      idleCycle();
      if (o_rsp_valid) seen = 1;
    end
    checkOutput({name, "_rsp"}, {31'b0, seen}, 32'h1);
    if (seen) begin
      checkOutput({name, "_instr"}, o_rsp_instr, expInstr);
      checkOutput({name, "_addr"}, o_rsp_addr, expAddr);
    end
  endtask

  task automatic waitRefill(input string name, input int minBeats, input int maxBeats);
    bit seen;
    seen = 0;
    for (int n = 0; n < 60 && !seen; n++) begin
      idleCycle();
      if (mState == 2 && beatsSent >= minBeats && beatsSent <= maxBeats) seen = 1;
    end
    checkOutput({name, "_refill"}, {31'b0, seen}, 32'h1);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

  int  rspCount;
  bit  gone;
  logic [31:0] ra;

  initial begin
    i_reset = 1'b1; i_req_valid = 1'b0; i_req_addr = '0; i_kill = 1'b0; i_flush = 1'b0;
    repeat (3) @(negedge clk);
    #4;
    checkOutput("lit_rst_ready", {31'b0, o_req_ready}, 32'h0);
    @(negedge clk);
    i_reset = 1'b0;
    #4;
    checkOutput("lit_ready_after_rst", {31'b0, o_req_ready}, 32'h1);

    // Cold miss on 0x10, then streaming hits over the rest of the line.
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0);
    waitMemReq("cold", 32'h10);
    waitRsp("cold", 32'hA0, 32'h10);
    applyStimulus(1'b1, 32'h14, 1'b0, 1'b0);
    applyStimulus(1'b1, 32'h18, 1'b0, 1'b0);
    #4;
    checkOutput("hit1_valid", {31'b0, o_rsp_valid}, 32'h1);
    checkOutput("hit1_instr", o_rsp_instr, 32'hA1);
    applyStimulus(1'b1, 32'h1C, 1'b0, 1'b0);
    #4;
    checkOutput("hit2_valid", {31'b0, o_rsp_valid}, 32'h1);
    checkOutput("hit2_instr", o_rsp_instr, 32'hA2);
    idleCycle();
    checkOutput("hit3_valid", {31'b0, o_rsp_valid}, 32'h1);
    checkOutput("hit3_instr", o_rsp_instr, 32'hA3);
    checkOutput("hit_no_memreq", {31'b0, o_mem_req_valid}, 32'h0);

    // Conflict eviction: 0x110 shares index 1 with 0x10.
    applyStimulus(1'b1, 32'h110, 1'b0, 1'b0);
    waitMemReq("conflict", 32'h110);
    waitRsp("conflict", 32'h10A0, 32'h110);
    applyStimulus(1'b1, 32'h10, 1'b0, 1'b0);
    waitMemReq("evicted", 32'h10);
    waitRsp("evicted", 32'hA0, 32'h10);

    // Kill during refill: no response, but the line is installed.
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b0);
    waitRefill("kill", 1, 2);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    #4;
    rspCount = o_rsp_valid ? 1 : 0;
    gone = 0;
    for (int n = 0; n < 40 && !gone; n++) begin
      idleCycle();
      if (o_rsp_valid) rspCount++;
      if (o_req_ready) gone = 1;
    end
    checkOutput("kill_no_rsp", rspCount, 32'h0);
    checkOutput("kill_back_idle", {31'b0, gone}, 32'h1);
    applyStimulus(1'b1, 32'h40, 1'b0, 1'b0);
    idleCycle();
    checkOutput("kill_rehit_valid", {31'b0, o_rsp_valid}, 32'h1);
    checkOutput("kill_rehit_instr", o_rsp_instr, 32'h3A0);

    // Flush in IDLE blocks the simultaneous request and forces a refetch.
    applyStimulus(1'b1, 32'h14, 1'b0, 1'b1);
    #4;
    checkOutput("flush_ready_low", {31'b0, o_req_ready}, 32'h0);
    applyStimulus(1'b1, 32'h14, 1'b0, 1'b0);
    waitMemReq("flush_refetch", 32'h10);
    waitRsp("flush_refetch", 32'hA1, 32'h14);

    // Flush during refill: pending response first, then one ready-low clear cycle.
    applyStimulus(1'b1, 32'h80, 1'b0, 1'b0);
    waitRefill("flush_mid", 1, 2);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b1);
    waitRsp("flush_mid", 32'h7A0, 32'h80);
    idleCycle();
    checkOutput("flush_mid_clear_ready", {31'b0, o_req_ready}, 32'h0);
    applyStimulus(1'b1, 32'h80, 1'b0, 1'b0);
    waitMemReq("flush_mid_refetch", 32'h80);
    waitRsp("flush_mid_refetch", 32'h7A0, 32'h80);

    // Reset after two of four beats: outputs drop at once, line stays invalid.
    beatLimit = 2;
    applyStimulus(1'b1, 32'h200, 1'b0, 1'b0);
    waitRefill("rst_mid", 2, 2);
    @(negedge clk);
    #2;
    i_reset = 1'b1;
    #1;
    checkOutput("async_rst_rsp_addr", o_rsp_addr, 32'h0);
    checkOutput("async_rst_rsp_instr", o_rsp_instr, 32'h0);
    checkOutput("async_rst_ready", {31'b0, o_req_ready}, 32'h0);
    checkOutput("async_rst_mem_valid", {31'b0, o_mem_req_valid}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    i_reset = 1'b0;
    beatLimit = 4;
    applyStimulus(1'b1, 32'h200, 1'b0, 1'b0);
    waitMemReq("rst_refetch", 32'h200);
    waitRsp("rst_refetch", 32'h1FA0, 32'h200);

    // Randomized traffic over 4 tags x 16 indexes, with occasional kill and flush.
    for (int i = 0; i < 600; i++) begin
      ra = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 15) << 4)
         | ($urandom_range(0, 3) << 2) | $urandom_range(0, 3);
      applyStimulus($urandom_range(0, 9) < 7, ra, $urandom_range(0, 19) == 0,
                    $urandom_range(0, 29) == 0);
    end
    repeat (60) idleCycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_cache.md
Name: instr_cache

Overview:
- Direct-mapped instruction cache that answers instruction fetch requests, replacing the fetch stage's flat instruction array.
- Hits return the instruction one cycle after the request is accepted.
- Misses run a line refill from backing memory, one word per beat, then return the requested word.
- Sits between the fetch stage (requester) and the backing instruction memory.

Parameters:
ADDR_WIDTH, 32, byte-address width of fetch and memory addresses
INSTR_WIDTH, 32, instruction/memory beat width in bits
NUM_LINES, 16, cache lines (power of 2)
WORDS_PER_LINE, 4, instructions per line (power of 2, >=2)

Ports:
i_clk  in  1  clock
i_reset  in  1  asynchronous active-high reset
i_req_valid  in  1  fetch request valid
i_req_addr  in  ADDR_WIDTH  fetch byte address; bits [1:0] ignored
o_req_ready  out  1  cache can accept a request this cycle
i_kill  in  1  discard any outstanding response (PC redirect)
i_flush  in  1  invalidate all lines (fence.i)
o_rsp_valid  out  1  one-cycle response pulse
o_rsp_instr  out  INSTR_WIDTH  returned instruction
o_rsp_addr  out  ADDR_WIDTH  address of returned instruction
o_mem_req_valid  out  1  line-refill request valid
o_mem_addr  out  ADDR_WIDTH  line-aligned refill base address
i_mem_req_ready  in  1  memory accepted refill request
i_mem_rsp_valid  in  1  refill data beat valid
i_mem_rsp_data  in  INSTR_WIDTH  refill data beat

Behaviour:
- Address split:
  - offset = bits [OFF-1:0], OFF = log2(WORDS_PER_LINE)+2
  - index = next log2(NUM_LINES) bits
  - tag = remaining upper bits
- Storage: data array, tag array, valid bit per line.
  - Valid bits are flops, cleared by reset and by flush.
- Reset values: all valid bits 0, state IDLE, beat counter 0, flush_pending 0.
  - All outputs 0, except o_req_ready = 1 once reset deasserts.
- Accept rule: a request is accepted when i_req_valid && o_req_ready.
  - o_req_ready = (state==IDLE) && !i_flush && !flush_pending.
- States:
  - IDLE: on accept, compare the tag of the indexed line.
    - Hit (valid && tag match): next cycle o_rsp_valid=1, o_rsp_instr=word, o_rsp_addr=request address; stay in IDLE. Back-to-back hits give one response per cycle.
    - Miss: latch address, go to MISS_REQ; no response.
  - MISS_REQ: hold o_mem_req_valid=1, o_mem_addr=line base (offset bits zero) until i_mem_req_ready, then go to REFILL.
  - REFILL: each i_mem_rsp_valid writes one beat to word[beat_cnt] and increments beat_cnt. Beats arrive in order, word 0 first.
    - On the last beat, write tag and set valid, clear beat_cnt, go to RESPOND.
  - RESPOND: o_rsp_valid=1 with the requested word (unless killed), go to IDLE.
    - Miss latency: response 1 cycle after the last beat.
- Kill:
  - i_kill in the cycle after a hit accept suppresses that hit's o_rsp_valid.
  - i_kill during MISS_REQ/REFILL/RESPOND sets kill_pending, so RESPOND produces no o_rsp_valid.
  - The refill still completes and the line stays valid.
  - kill_pending clears on return to IDLE.
- Flush:
  - i_flush in IDLE clears all valid bits at the next edge; o_req_ready=0 that cycle, so a simultaneous request is not accepted.
  - i_flush during a miss sets flush_pending; the miss completes and responds normally, then the valid clear happens in the first IDLE cycle with ready=0.
- Memory-side rules:
  - i_mem_rsp_valid outside REFILL is ignored.
  - A request accepted while a hit response is being emitted is legal (pipelined).
- Reset mid-operation: asynchronously returns to IDLE, drops o_mem_req_valid, clears valid bits and counters. Backing memory shares the reset, so an abandoned burst is never delivered.
- No misalignment trap: bits [1:0] are ignored and o_rsp_addr echoes the full address.

Test Plan:
- Cold miss: request 0x0000_0010 after reset.
  - o_mem_req_valid with o_mem_addr=0x0000_0010.
  - 4 beats of 0xA0..0xA3 → o_rsp_valid 1 cycle after the last beat, instr 0xA0, addr 0x10.
- Hit streaming: after the cold-miss refill, requests 0x14, 0x18, 0x1C on consecutive cycles.
  - Three consecutive responses 0xA1, 0xA2, 0xA3.
  - No memory request.
- Conflict eviction: request 0x0000_0110 (same index, different tag, with defaults).
  - Refill from 0x110 replaces the line.
  - A subsequent request to 0x10 misses again.
- Kill during refill: assert i_kill mid-REFILL.
  - No o_rsp_valid.
  - An immediate re-request of the same address hits with 1-cycle latency.
- Flush: i_flush with i_req_valid in IDLE.
  - o_req_ready=0 that cycle.
  - Next request to a previously cached address misses.
  - Flush asserted during REFILL still yields the pending response first.
- Reset mid-refill: assert i_reset after 2 of 4 beats.
  - Outputs go to 0 immediately.
  - After release, a request to the same line misses; no stale valid bit.
